// File: rtl/rvvi_seq_pkg.sv
// -----------------------------------------------------------------------------
// rvvi_seq_pkg
//   Shared types and widths for the RVVI retirement sequencer.
//   retire_rec_t is one retired instruction as presented on an RVVI slot.
// -----------------------------------------------------------------------------
package rvvi_seq_pkg;

  localparam int RVVI_SEQ_XLEN    = 32;
  localparam int RVVI_SEQ_ILEN    = 32;
  localparam int RVVI_SEQ_ORDER_W = 64;

  typedef struct packed {
    logic [RVVI_SEQ_ORDER_W-1:0] order;     // per-hart retirement sequence number
    logic [RVVI_SEQ_ILEN-1:0]    insn;
    logic [RVVI_SEQ_XLEN-1:0]    pc_rdata;
    logic [RVVI_SEQ_XLEN-1:0]    pc_wdata;
    logic                        trap;
    logic                        halt;
    logic                        intr;
    logic [1:0]                  mode;
    logic [1:0]                  ixl;
  } retire_rec_t;

endpackage

// File: rtl/rvvi_retire_sequencer_if.sv
// -----------------------------------------------------------------------------
// rvvi_retire_sequencer_if
//   Bundles the sequencer's producer and consumer signals.
//   Producer side : in_valid[h][s], in_rec[h][s] in; in_ready[h] out
//   Consumer side : out_valid, out_hart, out_rec out; out_ready in
//   Status        : level[h], order_err, order_err_hart
//   modport slave  : the sequencer
//   modport master : the environment (harts + consumer)
// -----------------------------------------------------------------------------
interface rvvi_retire_sequencer_if
  import rvvi_seq_pkg::*;
#(
  parameter int NHART = 1,
  parameter int NRET  = 1,
  parameter int DEPTH = 8
);
  localparam int HW = (NHART > 1) ? $clog2(NHART) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic        [NHART-1:0][NRET-1:0] in_valid;
  retire_rec_t [NHART-1:0][NRET-1:0] in_rec;
  logic        [NHART-1:0]           in_ready;
  logic                              out_valid;
  logic                              out_ready;
  logic        [HW-1:0]              out_hart;
  retire_rec_t                       out_rec;
  logic        [NHART-1:0][LW-1:0]   level;
  logic                              order_err;
  logic        [HW-1:0]              order_err_hart;

  modport slave (
    input  in_valid, in_rec, out_ready,
    output in_ready, out_valid, out_hart, out_rec, level, order_err, order_err_hart
  );

  modport master (
    output in_valid, in_rec, out_ready,
    input  in_ready, out_valid, out_hart, out_rec, level, order_err, order_err_hart
  );

endinterface

// File: rtl/rvvi_retire_fifo.sv
// -----------------------------------------------------------------------------
// rvvi_retire_fifo
//   Per-hart record buffer: up to NRET writes per cycle (valid slots compacted
//   in ascending slot order), one read per cycle.
//   Ports: clk, reset (sync, active-high), push_en (accept this cycle),
//          push_valid/push_rec (slots), pop (remove head),
//          count (occupancy), head (oldest record).
//   DEPTH must be a power of two and >= NRET; pointers wrap modulo DEPTH.
// -----------------------------------------------------------------------------
module rvvi_retire_fifo
  import rvvi_seq_pkg::*;
#(
  parameter  int NRET  = 1,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_en,
  input  logic        [NRET-1:0] push_valid,
  input  retire_rec_t [NRET-1:0] push_rec,
  input  logic                   pop,
  output logic        [CW-1:0]   count,
  output retire_rec_t            head
);

  retire_rec_t       mem_q [DEPTH];
  retire_rec_t       mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [CW-1:0]     n_push;
  logic              do_pop;

  // Masking with DEPTH-1 wraps a power-of-two buffer (and pins DEPTH=1 to 0).
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [CW-1:0] n);
    logic [31:0] sum;
    sum = (32'(p) + 32'(n)) & 32'(DEPTH - 1);
    return sum[PW-1:0];
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    mem_d  = mem_q;
    n_push = '0;
    if (push_en) begin
      for (int s = 0; s < NRET; s++) begin
        if (push_valid[s]) begin
          // n_push doubles as the compacted write offset for this slot.
          mem_d[ptr_add(wr_ptr_q, n_push)] = push_rec[s];
          n_push = n_push + CW'(1);
        end
      end
    end
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = ptr_add(wr_ptr_q, n_push);
    rd_ptr_d = do_pop ? ptr_add(rd_ptr_q, CW'(1)) : rd_ptr_q;
    count_d  = count_q + n_push - {{(CW-1){1'b0}}, do_pop};
  end

  // NOTE: record storage is deliberately not reset; count and the pointers
  // alone define which entries are live, so stale payload is never visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/rvvi_retire_sequencer.sv
// -----------------------------------------------------------------------------
// rvvi_retire_sequencer
//   Merges RVVI retirement records from NHART harts (NRET slots each) into a
//   single ready/valid stream, one record per cycle. Round-robin across harts,
//   program order preserved within a hart.
//   Ports: clk, reset (sync, active-high), bus (rvvi_retire_sequencer_if.slave)
//   Optional feature macro: RVVI_SEQ_ORDER_CHECK_EN -- per-hart order-gap
//   checker driving order_err / order_err_hart; tied to 0 when undefined.
// -----------------------------------------------------------------------------
module rvvi_retire_sequencer
  import rvvi_seq_pkg::*;
#(
  parameter int NHART = 1,
  parameter int NRET  = 1,
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  rvvi_retire_sequencer_if.slave  bus
);

  localparam int HW = (NHART > 1) ? $clog2(NHART) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]    count [NHART];
  retire_rec_t      head  [NHART];
  logic [NHART-1:0] nonempty;
  logic [NHART-1:0] in_ready;
  logic [NHART-1:0] pop;

  logic [HW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             lock_q, lock_d;
  logic [HW-1:0]    lock_hart_q, lock_hart_d;
  logic [HW-1:0]    scan_hart;
  logic             found;
  logic [HW-1:0]    grant;
  logic             out_valid;
  logic             fire;

  for (genvar h = 0; h < NHART; h++) begin : g_hart
    // Room for a full NRET-wide retirement, from registered occupancy only.
    assign in_ready[h] = (DEPTH - int'(count[h])) >= NRET;
    assign nonempty[h] = (count[h] != '0);
    assign pop[h]      = fire && (grant == HW'(h));
    assign bus.level[h] = count[h];

    rvvi_retire_fifo #(
      .NRET  (NRET),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_en    (in_ready[h]),
      .push_valid (bus.in_valid[h]),
      .push_rec   (bus.in_rec[h]),
      .pop        (pop[h]),
      .count      (count[h]),
      .head       (head[h])
    );
  end

  // First non-empty hart at or after rr_ptr, modulo NHART.
  always_comb begin
    scan_hart = rr_ptr_q;
    found     = 1'b0;
    for (int i = 0; i < NHART; i++) begin
      if (!found && nonempty[(int'(rr_ptr_q) + i) % NHART]) begin
        found     = 1'b1;
        scan_hart = HW'((int'(rr_ptr_q) + i) % NHART);
      end
    end
  end

  // A stalled offer stays pinned to its hart so a newly filled hart that
  // sits earlier in the scan cannot steal the grant before the handshake.
  assign grant     = lock_q ? lock_hart_q : scan_hart;
  // Nothing is offered while reset is asserted, so no record leaves that cycle.
  assign out_valid = (|nonempty) && !reset;
  assign fire      = out_valid && bus.out_ready;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    lock_hart_d = lock_hart_q;
    if (fire) begin
      rr_ptr_d = (grant == HW'(NHART - 1)) ? '0 : grant + HW'(1);
      lock_d   = 1'b0;
    end else if (out_valid) begin
      lock_d      = 1'b1;
      lock_hart_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      lock_hart_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      lock_hart_q <= lock_hart_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_hart  = grant;
  assign bus.out_rec   = head[grant];

`ifdef RVVI_SEQ_ORDER_CHECK_EN
  logic [RVVI_SEQ_ORDER_W-1:0] exp_q [NHART];
  logic [RVVI_SEQ_ORDER_W-1:0] exp_d [NHART];
  logic [NHART-1:0]            first_seen_q, first_seen_d;
  logic                        order_err_q, order_err_d;
  logic [HW-1:0]               order_err_hart_q, order_err_hart_d;

  always_comb begin
    exp_d            = exp_q;
    first_seen_d     = first_seen_q;
    order_err_d      = order_err_q;
    order_err_hart_d = order_err_hart_q;
    if (fire) begin
      // First pop of a hart only seeds the expectation.
      if (first_seen_q[grant] && (head[grant].order != exp_q[grant] + 1'b1)) begin
        order_err_d = 1'b1;
        if (!order_err_q) order_err_hart_d = grant;
      end
      // Resynchronise on every pop so one gap is reported once, not forever.
      exp_d[grant]        = head[grant].order;
      first_seen_d[grant] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int h = 0; h < NHART; h++) exp_q[h] <= '0;
      first_seen_q     <= '0;
      order_err_q      <= 1'b0;
      order_err_hart_q <= '0;
    end else begin
      exp_q            <= exp_d;
      first_seen_q     <= first_seen_d;
      order_err_q      <= order_err_d;
      order_err_hart_q <= order_err_hart_d;
    end
  end

  assign bus.order_err      = order_err_q;
  assign bus.order_err_hart = order_err_hart_q;
`else
  assign bus.order_err      = 1'b0;
  assign bus.order_err_hart = '0;
`endif

endmodule
